// File: rtl/jtcontra_gfx_romarb.sv
// Graphics ROM port arbiter: serialises tilemap (scr) and object (obj) fetches
// onto one SDRAM read port, round-robin on ties, with a one-cycle stale-ok guard.
module jtcontra_gfx_romarb #(
   parameter int AW = 18,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          scr_cs,
   input  logic [AW-1:0] scr_addr,
   output logic          scr_ok,
   output logic [DW-1:0] scr_data,
   input  logic          obj_cs,
   input  logic [AW-1:0] obj_addr,
   output logic          obj_ok,
   output logic [DW-1:0] obj_data,
   input  logic [1:0]    gfx_en,
   output logic          rom_cs,
   output logic [AW-1:0] rom_addr,
   input  logic          rom_ok,
   input  logic [DW-1:0] rom_data
);

   typedef enum logic [1:0] {IDLE, GUARD, BUSY} state_t;

   // channel index 0 = scr, 1 = obj
   state_t              state_q, state_d;
   logic [1:0]          cs, set, req, inflight;
   logic [1:0][AW-1:0]  addr;
   logic [1:0]          cs_prev_q, cs_prev_d;
   logic [1:0]          pend_q, pend_d;
   logic [1:0]          ok_q, ok_d;
   logic [1:0][DW-1:0]  data_q, data_d;
   logic [1:0][AW-1:0]  lat_q, lat_d;
   logic                gnt_q, gnt_d;
   logic                pick;
   logic                rom_cs_q, rom_cs_d;
   logic [AW-1:0]       rom_addr_q, rom_addr_d;

   assign cs   = {obj_cs, scr_cs};
   assign addr = {obj_addr, scr_addr};

   always_comb begin
      state_d    = state_q;
      cs_prev_d  = cs;
      pend_d     = pend_q;
      ok_d       = ok_q;
      data_d     = data_q;
      lat_d      = lat_q;
      gnt_d      = gnt_q;
      rom_cs_d   = rom_cs_q;
      rom_addr_d = rom_addr_q;
      set        = '0;
      inflight   = '0;
      req        = pend_q & gfx_en;
      // on a tie, gnt_q holds the last grant so the other channel wins
      pick       = (req == 2'b11) ? ~gnt_q : req[1];

      for (int i = 0; i < 2; i++) begin
         inflight[i] = (state_q != IDLE) && (gnt_q == 1'(i));
         set[i]      = cs[i] && (!cs_prev_q[i] || addr[i] != lat_q[i]);
         if (set[i]) begin
            pend_d[i] = 1'b1;
            ok_d[i]   = 1'b0;
         end else if (!cs[i] && !inflight[i]) begin
            pend_d[i] = 1'b0;
         end
         // disabled channels are answered locally with zeros
         if (pend_q[i] && !gfx_en[i] && !inflight[i]) begin
            pend_d[i] = 1'b0;
            ok_d[i]   = 1'b1;
            data_d[i] = '0;
            lat_d[i]  = addr[i];
         end
      end

      unique case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               gnt_d        = pick;
               rom_cs_d     = 1'b1;
               rom_addr_d   = addr[pick];
               lat_d[pick]  = addr[pick];
               pend_d[pick] = 1'b1;
               state_d      = GUARD;
            end else begin
               rom_cs_d = 1'b0;
            end
         end
         GUARD: state_d = BUSY;
         BUSY: begin
            if (rom_ok) begin
               rom_cs_d = 1'b0;
               state_d  = IDLE;
               if (cs[gnt_q] && addr[gnt_q] == lat_q[gnt_q]) begin
                  data_d[gnt_q] = rom_data;
                  ok_d[gnt_q]   = 1'b1;
                  pend_d[gnt_q] = 1'b0;
               end else begin
                  pend_d[gnt_q] = set[gnt_q];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cs_prev_q  <= '0;
         pend_q     <= '0;
         ok_q       <= '0;
         data_q     <= '0;
         lat_q      <= '0;
         gnt_q      <= 1'b1;
         rom_cs_q   <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         cs_prev_q  <= cs_prev_d;
         pend_q     <= pend_d;
         ok_q       <= ok_d;
         data_q     <= data_d;
         lat_q      <= lat_d;
         gnt_q      <= gnt_d;
         rom_cs_q   <= rom_cs_d;
         rom_addr_q <= rom_addr_d;
      end
   end

   assign scr_ok   = ok_q[0];
   assign obj_ok   = ok_q[1];
   assign scr_data = data_q[0];
   assign obj_data = data_q[1];
   assign rom_cs   = rom_cs_q;
   assign rom_addr = rom_addr_q;

endmodule
